inst_dispatcher: RTL and testbench

//  Producer side of the controller instruction handshake (inst / inst_valid / inst_exec_begins).

---
 rtl/inst_dispatcher_pkg.sv | 13 +
 rtl/inst_fifo.sv | 58 +++++
 rtl/inst_dispatcher.sv | 112 +++++++++++
 tb/tb_inst_dispatcher.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_dispatcher_pkg.sv
// Shared types for the instruction dispatcher.
// Holds the instruction word layout and the default queue depth.
package inst_dispatcher_pkg;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [23:0] operand;
    } instruction_t;

    localparam int INST_W = $bits(instruction_t);
    localparam int DISPATCH_FIFO_DEPTH = 8;

endpackage

// File: rtl/inst_fifo.sv
// Synchronous FIFO with registered storage and head output.
// A push is refused whenever the queue is full, even if a pop occurs in the same cycle.
module inst_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/inst_dispatcher.sv
// Queues host instructions and issues them one at a time to the controller,
// waiting for each completion pulse before issuing the next.
module inst_dispatcher
    import inst_dispatcher_pkg::*;
#(
    parameter int FIFO_DEPTH = DISPATCH_FIFO_DEPTH,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  instruction_t       host_inst,
    input  logic               host_inst_valid,
    output logic               host_inst_ready,
    input  logic               dispatch_en,
    output instruction_t       inst,
    output logic               inst_valid,
    input  logic               inst_exec_begins,
    output logic               busy,
    output logic               queue_empty,
    output logic [CNT_W-1:0]   done_count,
    output logic               proto_err
);

    typedef enum logic {
        IDLE,
        WAIT_DONE
    } state_t;

    state_t             state;
    state_t             next_state;
    logic               issue;
    logic               done_inc;
    logic               err_set;
    logic               fifo_full;
    logic               fifo_empty;
    logic [INST_W-1:0]  fifo_head;

    inst_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (INST_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (host_inst_valid),
        .push_data (host_inst),
        .pop       (issue),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign host_inst_ready = !fifo_full;
    assign queue_empty     = fifo_empty;
    assign busy            = (state == WAIT_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A completion may hand straight over to the next entry in the same cycle.
    always_comb begin
        next_state = state;
        issue      = 1'b0;
        done_inc   = 1'b0;
        err_set    = 1'b0;
        case (state)
            IDLE: begin
                err_set = inst_exec_begins;
                if (!fifo_empty && dispatch_en) begin
                    issue      = 1'b1;
                    next_state = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (inst_exec_begins) begin
                    done_inc = 1'b1;
                    if (!fifo_empty && dispatch_en) begin
                        issue = 1'b1;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst       <= '0;
            inst_valid <= 1'b0;
            done_count <= '0;
            proto_err  <= 1'b0;
        end else begin
            inst_valid <= issue;
            if (issue) begin
                inst <= instruction_t'(fifo_head);
            end
            if (done_inc) begin
                done_count <= done_count + CNT_W'(1);
            end
            if (err_set) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_inst_dispatcher.sv
// Directed bench for inst_dispatcher: vector table plus hand-written sequences.
// A narrow done_count makes the wrap reachable in a short run.
module tb_inst_dispatcher;
    import inst_dispatcher_pkg::*;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    instruction_t  host_inst;
    logic          host_inst_valid;
    logic          host_inst_ready;
    logic          dispatch_en;
    instruction_t  inst;
    logic          inst_valid;
    logic          inst_exec_begins;
    logic          busy;
    logic          queue_empty;
    logic [CW-1:0] done_count;
    logic          proto_err;

    int checks = 0;
    int errors = 0;
    int exp_done = 0;

    typedef struct {
        logic [31:0] hin;
        logic        hv;
        logic        ex;
        logic        e_valid;
        logic [31:0] e_inst;
        logic        e_busy;
        logic        e_empty;
        logic [31:0] e_done;
    } vec_t;

    vec_t tbl[5];

    always #5 clk = ~clk;

    inst_dispatcher #(
        .FIFO_DEPTH (8),
        .CNT_W      (CW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .host_inst        (host_inst),
        .host_inst_valid  (host_inst_valid),
        .host_inst_ready  (host_inst_ready),
        .dispatch_en      (dispatch_en),
        .inst             (inst),
        .inst_valid       (inst_valid),
        .inst_exec_begins (inst_exec_begins),
        .busy             (busy),
        .queue_empty      (queue_empty),
        .done_count       (done_count),
        .proto_err        (proto_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] v, input logic hv, input logic ex);
        host_inst        = instruction_t'(v);
        host_inst_valid  = hv;
        inst_exec_begins = ex;
    endtask

    function automatic logic [31:0] dmod(input int d);
        return 32'(d % (1 << CW));
    endfunction

    initial begin
        tbl[0] = '{32'hA500_0001, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'd0};
        tbl[1] = '{32'h0,         1'b0, 1'b0, 1'b1, 32'hA500_0001, 1'b1, 1'b1, 32'd0};
        tbl[2] = '{32'h0,         1'b0, 1'b0, 1'b0, 32'hA500_0001, 1'b1, 1'b1, 32'd0};
        tbl[3] = '{32'h0,         1'b0, 1'b1, 1'b0, 32'hA500_0001, 1'b0, 1'b1, 32'd1};
        tbl[4] = '{32'h0,         1'b0, 1'b0, 1'b0, 32'hA500_0001, 1'b0, 1'b1, 32'd1};

        rst_n = 1'b0;
        dispatch_en = 1'b1;
        drive(32'h0, 1'b0, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_empty", 32'(queue_empty), 32'd1);
        chk("rst_ready", 32'(host_inst_ready), 32'd1);
        chk("rst_done", 32'(done_count), 32'd0);
        chk("rst_err", 32'(proto_err), 32'd0);

        // reset in the middle of an outstanding instruction with 3 queued
        for (int i = 0; i < 5; i++) begin
            drive(32'h100 + 32'(i), 1'b1, 1'b0);
            tick();
        end
        drive(32'h0, 1'b0, 1'b1);
        tick();
        chk("pre_rst_inst", 32'(inst), 32'h101);
        chk("pre_rst_done", 32'(done_count), 32'd1);
        drive(32'h0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_inst", 32'(inst), 32'h0);
        chk("mid_rst_valid", 32'(inst_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done_count), 32'd0);
        chk("mid_rst_empty", 32'(queue_empty), 32'd1);
        chk("mid_rst_ready", 32'(host_inst_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk($sformatf("post_rst_noissue%0d", i), 32'(inst_valid), 32'd0);
        end
        exp_done = 0;

        // single instruction, cycle-by-cycle vectors
        for (int i = 0; i < 5; i++) begin
            drive(tbl[i].hin, tbl[i].hv, tbl[i].ex);
            tick();
            chk($sformatf("v%0d_valid", i), 32'(inst_valid), 32'(tbl[i].e_valid));
            chk($sformatf("v%0d_inst", i), 32'(inst), tbl[i].e_inst);
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
            chk($sformatf("v%0d_empty", i), 32'(queue_empty), 32'(tbl[i].e_empty));
            chk($sformatf("v%0d_done", i), 32'(done_count), tbl[i].e_done);
        end
        exp_done = 1;

        // back-to-back: completion 5 cycles after each issue
        drive(32'h300, 1'b1, 1'b0);
        tick();
        drive(32'h301, 1'b1, 1'b0);
        tick();
        chk("b2b_first_valid", 32'(inst_valid), 32'd1);
        chk("b2b_first_inst", 32'(inst), 32'h300);
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (i == 0 && j == 0) drive(32'h302, 1'b1, 1'b0);
                else drive(32'h0, 1'b0, 1'b0);
                tick();
                chk($sformatf("b2b%0d_gap%0d", i, j), 32'(inst_valid), 32'd0);
            end
            drive(32'h0, 1'b0, 1'b1);
            tick();
            exp_done++;
            chk($sformatf("b2b%0d_done", i), 32'(done_count), dmod(exp_done));
            if (i < 2) begin
                chk($sformatf("b2b%0d_next_valid", i), 32'(inst_valid), 32'd1);
                chk($sformatf("b2b%0d_next_inst", i), 32'(inst), 32'h301 + 32'(i));
            end else begin
                chk("b2b_last_valid", 32'(inst_valid), 32'd0);
                chk("b2b_last_busy", 32'(busy), 32'd0);
            end
        end
        drive(32'h0, 1'b0, 1'b0);
        tick();

        // fill: 9 pushes, one issued and eight queued
        for (int i = 0; i < 9; i++) begin
            drive(32'h400 + 32'(i), 1'b1, 1'b0);
            tick();
        end
        chk("full_ready", 32'(host_inst_ready), 32'd0);
        chk("full_inst", 32'(inst), 32'h400);
        chk("full_busy", 32'(busy), 32'd1);
        drive(32'h4EE, 1'b1, 1'b0);
        tick();
        drive(32'h0, 1'b0, 1'b0);
        for (int i = 1; i < 9; i++) begin
            drive(32'h0, 1'b0, 1'b1);
            tick();
            exp_done++;
            chk($sformatf("drain%0d_valid", i), 32'(inst_valid), 32'd1);
            chk($sformatf("drain%0d_inst", i), 32'(inst), 32'h400 + 32'(i));
            drive(32'h0, 1'b0, 1'b0);
            tick();
        end
        drive(32'h0, 1'b0, 1'b1);
        tick();
        exp_done++;
        chk("drain_end_busy", 32'(busy), 32'd0);
        chk("drain_end_valid", 32'(inst_valid), 32'd0);
        chk("drain_end_empty", 32'(queue_empty), 32'd1);
        chk("drain_end_done", 32'(done_count), dmod(exp_done));
        drive(32'h0, 1'b0, 1'b0);
        tick();

        // pause
        for (int i = 0; i < 3; i++) begin
            drive(32'h500 + 32'(i), 1'b1, 1'b0);
            tick();
        end
        chk("pause_issue_inst", 32'(inst), 32'h500);
        drive(32'h0, 1'b0, 1'b0);
        dispatch_en = 1'b0;
        tick();
        drive(32'h0, 1'b0, 1'b1);
        tick();
        exp_done++;
        chk("pause_done", 32'(done_count), dmod(exp_done));
        chk("pause_busy", 32'(busy), 32'd0);
        chk("pause_valid", 32'(inst_valid), 32'd0);
        drive(32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("paused%0d_valid", i), 32'(inst_valid), 32'd0);
        end
        chk("paused_empty", 32'(queue_empty), 32'd0);
        dispatch_en = 1'b1;
        tick();
        chk("resume_valid", 32'(inst_valid), 32'd1);
        chk("resume_inst", 32'(inst), 32'h501);
        tick();
        chk("resume_pulse", 32'(inst_valid), 32'd0);
        drive(32'h0, 1'b0, 1'b1);
        tick();
        exp_done++;
        chk("resume2_inst", 32'(inst), 32'h502);
        drive(32'h0, 1'b0, 1'b0);
        tick();
        drive(32'h0, 1'b0, 1'b1);
        tick();
        exp_done++;
        chk("pause_final_done", 32'(done_count), dmod(exp_done));
        drive(32'h0, 1'b0, 1'b0);
        tick();

        // protocol error in IDLE
        chk("pre_err", 32'(proto_err), 32'd0);
        drive(32'h0, 1'b0, 1'b1);
        tick();
        chk("err_set", 32'(proto_err), 32'd1);
        chk("err_done", 32'(done_count), dmod(exp_done));
        drive(32'h0, 1'b0, 1'b0);
        tick();

        // done_count wrap: 16 further completions pass through 15 -> 0
        for (int i = 0; i < 16; i++) begin
            drive(32'h600 + 32'(i), 1'b1, 1'b0);
            tick();
            drive(32'h0, 1'b0, 1'b0);
            tick();
            drive(32'h0, 1'b0, 1'b1);
            tick();
            exp_done++;
            chk($sformatf("wrap%0d_done", i), 32'(done_count), dmod(exp_done));
            if (dmod(exp_done) == 32'd0) begin
                chk("wrap_zero", 32'(done_count), 32'd0);
            end
        end
        drive(32'h0, 1'b0, 1'b0);
        tick();
        chk("err_sticky", 32'(proto_err), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
